// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, CPOL/CPHA extraction, and the FSM
// state encoding also used by spi_master.
package spi_pkg;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  function automatic logic spi_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input int mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_2ff.sv
// Two-flop synchronizer for one asynchronous SPI pin, with a configurable reset value.
// Latency: 2 clk cycles. Backpressure: none.
module spi_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave, modes 0-3; LSB-first order selected by SPI_SLAVE_LSB_FIRST_EN.
// Latency: SCLK pin edge to rx_data_valid_o 3-4 clk. Backpressure: single TX hold register; IDLE_BYTE on underrun.
module spi_slave
  import spi_pkg::*;
#(
  parameter int         SPI_MODE  = 0,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] tx_data_byte_i,
  input  logic       tx_data_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_byte_o,
  output logic       rx_data_valid_o,
  input  logic       spi_clk_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  logic sclk_s, sclk_d, cs_s, cs_d, mosi_s;

  spi_sync_2ff #(.RST_VAL(CPOL)) u_sync_sclk (.clk(clk_i), .rst(reset_i), .d(spi_clk_i),  .q(sclk_s));
  spi_sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk_i), .rst(reset_i), .d(spi_cs_n_i), .q(cs_s));
  spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk_i), .rst(reset_i), .d(spi_mosi_i), .q(mosi_s));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_d <= CPOL;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  logic leading, trailing, sample_edge, drive_edge, cs_fall;
  assign leading     = (sclk_d == CPOL) && (sclk_s != CPOL);
  assign trailing    = (sclk_d != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trailing : leading;
  assign drive_edge  = CPHA ? leading : trailing;
  assign cs_fall     = cs_d & ~cs_s;

  spi_state_t state_q, state_d;
  logic       active, enter, load, shift;
  logic [2:0] tx_cnt, rx_cnt;
  logic [7:0] tx_shift, tx_hold, rx_shift, rx_next, tx_shifted, load_byte;
  logic       hold_full, hs;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A raised CS_N masks any SCLK edge detected in the same cycle.
  always_comb begin
    state_d = state_q;
    active  = 1'b0;
    enter   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          enter   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_s) state_d = ST_IDLE;
        else      active  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (CPHA == 1'b0) begin
      load  = enter | (active & drive_edge & (tx_cnt == 3'd7));
      shift = active & drive_edge & (tx_cnt != 3'd7);
    end else begin
      load  = active & drive_edge & (tx_cnt == 3'd0);
      shift = active & drive_edge & (tx_cnt != 3'd0);
    end
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_shift[7:1]};
  assign tx_shifted = {1'b0, tx_shift[7:1]};
  assign spi_miso_o = tx_shift[0];
`else
  assign rx_next    = {rx_shift[6:0], mosi_s};
  assign tx_shifted = {tx_shift[6:0], 1'b0};
  assign spi_miso_o = tx_shift[7];
`endif

  assign tx_ready_o    = ~hold_full;
  assign hs            = tx_data_valid_i & ~hold_full;
  assign load_byte     = hold_full ? tx_hold : (hs ? tx_data_byte_i : IDLE_BYTE);
  assign spi_miso_oe_o = (state_q == ST_ACTIVE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_shift        <= 8'h00;
      tx_hold         <= 8'h00;
      hold_full       <= 1'b0;
      tx_cnt          <= 3'd0;
      rx_shift        <= 8'h00;
      rx_cnt          <= 3'd0;
      rx_data_byte_o  <= 8'h00;
      rx_data_valid_o <= 1'b0;
    end else begin
      rx_data_valid_o <= 1'b0;
      // A handshake coinciding with a load on an empty hold bypasses the hold.
      if (load) begin
        tx_shift  <= load_byte;
        hold_full <= 1'b0;
      end else begin
        if (hs) begin
          tx_hold   <= tx_data_byte_i;
          hold_full <= 1'b1;
        end
        if (shift) tx_shift <= tx_shifted;
      end
      if (!active)         tx_cnt <= 3'd0;
      else if (drive_edge) tx_cnt <= tx_cnt + 3'd1;
      if (!active) begin
        rx_cnt <= 3'd0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        rx_cnt   <= rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) begin
          rx_data_byte_o  <= rx_next;
          rx_data_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a bit-banged master model.
// RX and MISO bytes are checked against scoreboard queues filled as stimulus is driven.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk, cs_n, tx_vld;
  logic [7:0] tx_dat;
  logic       mosi;
  logic [3:0] tx_rdy, rx_vld, miso, oe;
  logic [7:0] rx_dat [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .IDLE_BYTE(8'h00)) u_dut (
      .clk_i          (clk),
      .reset_i        (rst),
      .tx_data_byte_i (tx_dat),
      .tx_data_valid_i(tx_vld[g]),
      .tx_ready_o     (tx_rdy[g]),
      .rx_data_byte_o (rx_dat[g]),
      .rx_data_valid_o(rx_vld[g]),
      .spi_clk_i      (sclk[g]),
      .spi_cs_n_i     (cs_n[g]),
      .spi_mosi_i     (mosi),
      .spi_miso_o     (miso[g]),
      .spi_miso_oe_o  (oe[g])
    );
  end

  typedef struct {
    int         mode;
    logic [7:0] tx;
    logic [7:0] mosi_byte;
    logic [7:0] exp_rx;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         cur = 0;
  int         rx_pulses = 0;
  logic       first_miso;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  vec_t       vecs[6];

  function automatic int bidx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rx_vld[cur]) begin
      rx_pulses++;
      if (exp_rx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_dat[cur]);
      end else begin
        chk("rx_byte", rx_dat[cur], exp_rx.pop_front());
      end
    end
  endtask

  task automatic push(input int m, input logic [7:0] v);
    int n = 0;
    while (!tx_rdy[m] && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", tx_rdy[m], 1);
    tx_dat    = v;
    tx_vld[m] = 1'b1;
    tick();
    tx_vld[m] = 1'b0;
    exp_miso.push_back(v);
    tick();
  endtask

  // Master model: 8 clk per SCLK period; push_at selects the byte during which a mid-byte TX push happens.
  task automatic run_frame(input int m, input int nb, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int last_bits, input int push_at,
                           input logic [7:0] push_val);
    logic       cp, ch;
    logic [7:0] mo [3];
    logic [7:0] got;
    int         total, full;
    cp = (m >= 2);
    ch = (m % 2 == 1);
    mo[0] = b0; mo[1] = b1; mo[2] = b2;
    total = (nb - 1) * 8 + last_bits;
    full = (last_bits == 8) ? nb : nb - 1;
    got = 8'h00;
    cur = m;
    rx_pulses = 0;
    if (!ch) mosi = mo[0][bidx(0)];
    cs_n[m] = 1'b0;
    repeat (8) tick();
    chk("oe_active", oe[m], 1);
    for (int k = 0; k < total; k++) begin
      int bi, by;
      bi = bidx(k % 8);
      by = k / 8;
      if (k % 8 == 0) begin
        if (exp_miso.size() == 0) exp_miso.push_back(8'h00);
        if (by < full) exp_rx.push_back(mo[by]);
      end
      if (ch) begin
        sclk[m] = ~cp;
        mosi = mo[by][bi];
      end else begin
        if (k == 0) first_miso = miso[m];
        got[bi] = miso[m];
        sclk[m] = ~cp;
      end
      if (k == push_at * 8 + 2) begin
        tx_dat = push_val;
        tx_vld[m] = 1'b1;
        tick();
        tx_vld[m] = 1'b0;
        exp_miso.push_back(push_val);
        repeat (3) tick();
      end else begin
        repeat (4) tick();
      end
      if (ch) begin
        if (k == 0) first_miso = miso[m];
        got[bi] = miso[m];
        sclk[m] = cp;
      end else begin
        sclk[m] = cp;
        if (k + 1 < total) mosi = mo[(k + 1) / 8][bidx((k + 1) % 8)];
      end
      repeat (4) tick();
      if (k % 8 == 7) begin
        if (exp_miso.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL miso_unexpected actual=%0h required=none", got);
        end else begin
          chk("miso_byte", got, exp_miso.pop_front());
        end
      end
    end
    repeat (4) tick();
    cs_n[m] = 1'b1;
    repeat (8) tick();
    chk("oe_idle", oe[m], 0);
    chk("rx_pulses", rx_pulses, full);
    chk("rx_missing", exp_rx.size(), 0);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C};
    vecs[1] = '{1, 8'h96, 8'h5A, 8'h5A};
    vecs[2] = '{2, 8'h96, 8'h5A, 8'h5A};
    vecs[3] = '{3, 8'h96, 8'h5A, 8'h5A};
    vecs[4] = '{0, 8'hFF, 8'h00, 8'h00};
    vecs[5] = '{3, 8'h00, 8'hFF, 8'hFF};

    rst = 1'b1;
    tx_vld = 4'h0;
    tx_dat = 8'h00;
    mosi = 1'b0;
    cs_n = 4'hF;
    sclk = 4'b1100;
    repeat (2) tick();
    chk("rst_tx_ready", tx_rdy, 4'hF);
    chk("rst_rx_valid", rx_vld, 4'h0);
    chk("rst_miso", miso, 4'h0);
    chk("rst_oe", oe, 4'h0);
    for (int i = 0; i < 4; i++) chk("rst_rx_byte", rx_dat[i], 0);
    rst = 1'b0;
    repeat (4) tick();

    // Single-byte exchanges across all modes
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].mode, vecs[i].tx);
      chk("hold_full_ready", tx_rdy[vecs[i].mode], 0);
      run_frame(vecs[i].mode, 1, vecs[i].mosi_byte, 8'h00, 8'h00, 8, -1, 8'h00);
      chk("ready_after", tx_rdy[vecs[i].mode], 1);
      chk("rx_last", rx_dat[vecs[i].mode], vecs[i].exp_rx);
    end

    // Three back-to-back bytes, second queued mid-byte, third underruns
    push(0, 8'h11);
    run_frame(0, 3, 8'hC1, 8'h7E, 8'h2B, 8, 0, 8'h22);
    chk("b2b_rx_last", rx_dat[0], 8'h2B);

    // CS_N abort after 5 bits keeps the held byte
    push(0, 8'h77);
    run_frame(0, 1, 8'hB4, 8'h00, 8'h00, 5, 0, 8'h88);
    chk("abort_hold_kept", tx_rdy[0], 0);
    chk("abort_rx_unchanged", rx_dat[0], 8'h2B);
    void'(exp_miso.pop_front());
    run_frame(0, 1, 8'hE1, 8'h00, 8'h00, 8, -1, 8'h00);
    chk("abort_next_ready", tx_rdy[0], 1);

    // Asynchronous reset in the middle of a byte
    cur = 0;
    push(0, 8'h33);
    cs_n[0] = 1'b0;
    mosi = 1'b1;
    repeat (8) tick();
    push(0, 8'h44);
    chk("mid_hold_full", tx_rdy[0], 0);
    for (int i = 0; i < 3; i++) begin
      sclk[0] = 1'b1;
      repeat (4) tick();
      sclk[0] = 1'b0;
      repeat (4) tick();
    end
    #3 rst = 1'b1;
    #1;
    chk("arst_tx_ready", tx_rdy[0], 1);
    chk("arst_oe", oe[0], 0);
    chk("arst_rx_valid", rx_vld[0], 0);
    chk("arst_miso", miso[0], 0);
    cs_n[0] = 1'b1;
    exp_miso.delete();
    exp_rx.delete();
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    push(0, 8'h5A);
    run_frame(0, 1, 8'hC3, 8'h00, 8'h00, 8, -1, 8'h00);
    chk("post_rst_rx", rx_dat[0], 8'hC3);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    push(0, 8'h01);
    run_frame(0, 1, 8'h80, 8'h00, 8'h00, 8, -1, 8'h00);
    chk("lsb_first_miso_bit", first_miso, 1);
    chk("lsb_rx", rx_dat[0], 8'h80);
`else
    push(0, 8'h80);
    run_frame(0, 1, 8'h01, 8'h00, 8'h00, 8, -1, 8'h00);
    chk("msb_first_miso_bit", first_miso, 1);
    chk("msb_rx", rx_dat[0], 8'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) that pairs with spi_master across the same 4-wire link.
- Oversamples spi_clk_i, spi_cs_n_i and spi_mosi_i in the clk_i domain, then detects SCLK edges.
- Shifts bytes in and out MSB-first in one of SPI modes 0-3.
- Presents the same byte-level TX valid/ready and RX valid-pulse interface to local logic as the master does.

Parameters:
- SPI_MODE, 0: 0-3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]. Must match the master.
- IDLE_BYTE, 8'h00: byte shifted out on MISO when no TX byte is queued (underrun).

Ports:
- clk_i  in  1  system clock; must be ≥ 8x SCLK frequency.
- reset_i  in  1  asynchronous, active-high reset.
- tx_data_byte_i  in  8  byte to return on MISO.
- tx_data_valid_i  in  1  TX byte valid.
- tx_ready_o  out  1  TX holding register empty; transfer occurs when valid && ready.
- rx_data_byte_o  out  8  last complete byte received on MOSI.
- rx_data_valid_o  out  1  one-cycle pulse when rx_data_byte_o updates.
- spi_clk_i  in  1  SCLK from master (asynchronous).
- spi_cs_n_i  in  1  chip select, active-low (asynchronous).
- spi_mosi_i  in  1  MOSI (asynchronous).
- spi_miso_o  out  1  MISO data.
- spi_miso_oe_o  out  1  MISO output enable; high only while selected.

Behaviour:
- **Reset (async, reset_i=1):**
  - Synchronizers load their idle values: SCLK=CPOL, CS_N=1, MOSI=0.
  - Counters, shift registers and hold register are cleared.
  - tx_ready_o=1, rx_data_byte_o=8'h00, rx_data_valid_o=0, spi_miso_o=0, spi_miso_oe_o=0.
- **Input sync:** each SPI input passes through a 2-flop synchronizer plus one history flop.
  - Edge detect uses the last two synchronized samples.
  - Leading edge = SCLK transition away from CPOL; trailing edge = transition back to CPOL.
- **Edge roles:**
  - Sample edge: leading if CPHA=0, trailing if CPHA=1.
  - Drive edge: the opposite edge.
- **FSM, two states:**
  - IDLE: entered on reset or when synchronized CS_N goes high. spi_miso_oe_o=0; rx_cnt=tx_cnt=0; SCLK edges ignored.
  - ACTIVE: entered on the synchronized CS_N falling edge; spi_miso_oe_o=1.
- **TX load:** "load" moves tx_hold into tx_shift when the hold register is full, else loads IDLE_BYTE.
  - Hold is emptied by a load, and tx_ready_o rises the following cycle.
  - If a load and a handshake fall in the same cycle with hold empty, the incoming byte goes straight to tx_shift and hold stays empty.
  - A handshake with no load in that cycle fills hold; tx_ready_o=0 next cycle.
- **TX drive, CPHA=0:**
  - Load on IDLE→ACTIVE.
  - On each drive (trailing) edge: if tx_cnt==7, load and set tx_cnt=0; else shift left and increment tx_cnt.
- **TX drive, CPHA=1:**
  - On each drive (leading) edge: if tx_cnt==0, load; else shift left. Then tx_cnt = tx_cnt+1 mod 8.
- **MISO:** spi_miso_o = tx_shift[7], registered.
- **RX:**
  - On each sample edge in ACTIVE: rx_shift <= {rx_shift[6:0], mosi_sync}; rx_cnt increments (3-bit, wraps).
  - When rx_cnt==7 at a sample edge: rx_data_byte_o <= {rx_shift[6:0], mosi_sync}, and rx_data_valid_o=1 for exactly one cycle.
  - Latency from the SCLK pin edge to rx_data_valid_o: 3-4 clk_i cycles.
- **Back-to-back bytes:** with CS_N held low, bytes stream continuously with no gap cycles; counters wrap.
- **CS_N deassert mid-byte:**
  - Partial RX byte is discarded and no valid pulse is issued.
  - Partially sent TX byte is dropped.
  - Hold register contents are retained for the next transaction.
- **Simultaneous CS_N rise and sample edge:** CS_N wins and the edge is ignored.
- **Reset mid-transfer:** everything aborts immediately; no valid pulse is issued.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both directions are LSB-first.
  - MISO = tx_shift[0], and tx_shift shifts right.
  - RX shifts right: rx_shift <= {mosi_sync, rx_shift[7:1]}.
- Undefined: MSB-first as above.
- Port list is identical in both cases.

Decomposition:
- Package spi_pkg holds:
  - SPI mode constants SPI_MODE0..3.
  - cpol/cpha extraction functions.
  - FSM state encoding (ST_IDLE, ST_ACTIVE), shared with spi_master.
- One sub-module, spi_sync_2ff (parameterized reset value). It is instantiated 3 times for SCLK, CS_N and MOSI.

Test Plan:
1. Mode 0, clk_i:SCLK = 8:1:
   - Preload 0xA5; master sends 0x3C.
   - Expect MISO 0xA5, rx_data_byte_o=0x3C with a single rx_data_valid_o pulse, and tx_ready_o re-asserted.
2. Modes 1, 2, 3 each:
   - Preload 0x96; master sends 0x5A.
   - Expect bit-exact exchange in both directions.
3. Three back-to-back bytes in one CS frame:
   - Preload 0x11, then 0x22 queued during byte 1, and nothing for byte 3.
   - Expect MISO 0x11, 0x22, IDLE_BYTE (0x00), and three RX valid pulses.
4. CS_N raised after 5 bits with 0x77 preloaded and 0x88 queued in hold:
   - Expect no RX pulse and 0x88 still held (tx_ready_o=0).
   - Next frame returns 0x88 first.
5. reset_i pulsed asynchronously mid-byte:
   - Expect immediate tx_ready_o=1, spi_miso_oe_o=0, rx_data_valid_o=0, and clean operation on the next frame.
6. With SPI_SLAVE_LSB_FIRST_EN:
   - Preload 0x01; master sends 0x80.
   - Expect the first MISO bit = 1 and rx_data_byte_o=0x80.
